// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vram_arb_pkg;

    localparam int VRAM_A    = 12;   // RAM address width (4 KiB)
    localparam int VRAM_D    = 8;    // data width
    localparam int VRAM_LENW = 8;    // DMA length field; 0 encodes 2^LENW bytes

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_DMA  = 2'd2
    } arb_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/dma_addr_gen.sv
// DMA burst address generator: latches base/length, steps a byte offset, flags the final byte.
// Latency: addr/last are combinational from registered state; load/step take effect next cycle.
// Backpressure: none; the arbiter steps it only when a DMA slot is actually issued.
module dma_addr_gen #(
    parameter int A    = 12,
    parameter int LENW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [A-1:0]    base,
    input  logic [LENW-1:0] len,
    input  logic            step,
    output logic [A-1:0]    addr,
    output logic            last
);

    logic [A-1:0]    base_q;
    logic [LENW-1:0] last_off;   // len-1; a zero length wraps to all-ones, i.e. 2^LENW bytes
    logic [LENW-1:0] offset;

    // Latch burst parameters on accept, advance the offset once per issued byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q   <= '0;
            last_off <= '0;
            offset   <= '0;
        end else if (load) begin
            base_q   <= base;
            last_off <= len - LENW'(1);
            offset   <= '0;
        end else if (step) begin
            offset   <= offset + LENW'(1);
        end
    end

    // Address wraps silently at the top of the RAM through natural truncation
    assign addr = base_q + A'(offset);
    assign last = (offset == last_off);

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the single async VRAM between the CPU port and a video DMA burst reader.
// Latency: CPU req->gnt 1 cycle, req->read data 2 cycles; DMA one byte per cycle, data one cycle after its slot.
// Backpressure: CPU holds cpu_req until cpu_gnt; dma_start is ignored while dma_busy. Optional VRAM_ARB_CPU_PREEMPT_EN lets the CPU cut into a burst.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int A    = VRAM_A,
    parameter int D    = VRAM_D,
    parameter int LENW = VRAM_LENW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cpu_req,
    input  logic            cpu_rw,
    input  logic [A-1:0]    cpu_addr,
    input  logic [D-1:0]    cpu_di,
    output logic            cpu_gnt,
    output logic [D-1:0]    cpu_do,
    output logic            cpu_valid,
    input  logic            dma_start,
    input  logic [A-1:0]    dma_base,
    input  logic [LENW-1:0] dma_len,
    output logic            dma_busy,
    output logic [D-1:0]    dma_data,
    output logic            dma_valid,
    output logic            dma_done,
    output logic            ram_cs,
    output logic            ram_rw,
    output logic [A-1:0]    ram_addr,
    output logic [D-1:0]    ram_di,
    input  logic [D-1:0]    ram_do
);

    arb_state_t     state;
    logic           slot_last;   // the DMA slot now on the bus carries the final burst byte
    logic           start_acc;
    logic           issue_dma;
    logic           issue_cpu;
    logic [A-1:0]   gen_addr;
    logic           gen_last;

    assign start_acc = dma_start && !dma_busy;

    dma_addr_gen #(
        .A    (A),
        .LENW (LENW)
    ) u_addr_gen (
        .clk   (clk),
        .reset (reset),
        .load  (start_acc),
        .base  (dma_base),
        .len   (dma_len),
        .step  (issue_dma),
        .addr  (gen_addr),
        .last  (gen_last)
    );

    // Pick the owner of the next slot; a burst being accepted this cycle already beats the CPU
    always_comb begin
        issue_dma = 1'b0;
        issue_cpu = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (dma_busy)
                    issue_dma = 1'b1;
                else if (cpu_req && !start_acc)
                    issue_cpu = 1'b1;
            end
            ARB_CPU: begin
`ifdef VRAM_ARB_CPU_PREEMPT_EN
                // an interrupted burst resumes straight after the inserted CPU slot
                if (dma_busy)
                    issue_dma = 1'b1;
`endif
            end
            ARB_DMA: begin
                if (!slot_last) begin
`ifdef VRAM_ARB_CPU_PREEMPT_EN
                    if (cpu_req)
                        issue_cpu = 1'b1;
                    else
                        issue_dma = 1'b1;
`else
                    issue_dma = 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

    // Arbiter FSM: registered RAM controls, result capture and handshake pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            slot_last <= 1'b0;
            cpu_gnt   <= 1'b0;
            cpu_do    <= '0;
            cpu_valid <= 1'b0;
            dma_busy  <= 1'b0;
            dma_data  <= '0;
            dma_valid <= 1'b0;
            dma_done  <= 1'b0;
            ram_cs    <= 1'b0;
            ram_rw    <= RW_WRITE;
            ram_addr  <= '0;
            ram_di    <= '0;
        end else begin
            cpu_gnt   <= 1'b0;
            cpu_valid <= 1'b0;
            dma_valid <= 1'b0;
            dma_done  <= 1'b0;
            ram_cs    <= 1'b0;

            // results of the slot that ends at this edge
            if (state == ARB_CPU && ram_rw == RW_READ) begin
                cpu_do    <= ram_do;
                cpu_valid <= 1'b1;
            end
            if (state == ARB_DMA) begin
                dma_data  <= ram_do;
                dma_valid <= 1'b1;
                if (slot_last) begin
                    dma_done <= 1'b1;
                    dma_busy <= 1'b0;
                end
            end

            if (start_acc)
                dma_busy <= 1'b1;

            // next slot
            if (issue_dma) begin
                state     <= ARB_DMA;
                ram_cs    <= 1'b1;
                ram_rw    <= RW_READ;
                ram_addr  <= gen_addr;
                slot_last <= gen_last;
            end else if (issue_cpu) begin
                state     <= ARB_CPU;
                ram_cs    <= 1'b1;
                ram_rw    <= cpu_rw;
                ram_addr  <= cpu_addr;
                ram_di    <= cpu_di;
                cpu_gnt   <= 1'b1;
            end else begin
                state     <= ARB_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: async RAM model, monitor queues and a shadow memory reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_vram_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_rw;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_di;
    logic        cpu_gnt, cpu_valid;
    logic [7:0]  cpu_do;
    logic        dma_start;
    logic [11:0] dma_base;
    logic [7:0]  dma_len;
    logic        dma_busy, dma_valid, dma_done;
    logic [7:0]  dma_data;
    logic        ram_cs, ram_rw;
    logic [11:0] ram_addr;
    logic [7:0]  ram_di, ram_do;

    int n_cmp = 0;
    int n_fail = 0;

    vram_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
        .cpu_gnt(cpu_gnt), .cpu_do(cpu_do), .cpu_valid(cpu_valid),
        .dma_start(dma_start), .dma_base(dma_base), .dma_len(dma_len),
        .dma_busy(dma_busy), .dma_data(dma_data), .dma_valid(dma_valid), .dma_done(dma_done),
        .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        if (i == 12'h234) return 8'h5A;
        return 8'((i * 37 + (i >> 4) * 11) ^ 8'h5C);
    endfunction

    // Async RAM: same-cycle read, write at the end of a write slot
    logic [7:0] mem [4096];
    assign ram_do = mem[ram_addr];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (ram_cs && !ram_rw) mem[ram_addr] <= ram_di;
        end
    end

    // Reference: what the RAM should hold, from the bench's own writes
    logic [7:0] shadow [4096];

    // Monitor
    logic [7:0] dma_q[$];
    int         dma_cyc[$];
    int         slot_cyc[$];
    string      slot_log = "";
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_at = 0;
    int         gnt_busy_cnt = 0;
    always @(negedge clk) begin
        cyc++;
        if (dma_valid) begin
            dma_q.push_back(dma_data);
            dma_cyc.push_back(cyc);
        end
        if (dma_done) begin
            done_cnt++;
            done_at = dma_q.size();
        end
        if (cpu_gnt && dma_busy) gnt_busy_cnt++;
        if (ram_cs) begin
            slot_cyc.push_back(cyc);
            if (cpu_gnt) slot_log = {slot_log, "C"};
            else         slot_log = {slot_log, "D"};
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- drivers ----------------
    task automatic dma_go(input logic [11:0] b, input logic [7:0] l);
        @(posedge clk); #1;
        dma_start = 1'b1; dma_base = b; dma_len = l;
        @(posedge clk); #1;
        dma_start = 1'b0;
    endtask

    task automatic cpu_access(input logic rw, input logic [11:0] a, input logic [7:0] d,
                              output logic [7:0] rd, output int gnt_wait, output bit ok);
        int n;
        n = 0; ok = 1'b1; rd = '0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_di = d;
        do begin @(negedge clk); n++; end while (!cpu_gnt && n < 700);
        gnt_wait = n;
        if (!cpu_gnt) ok = 1'b0;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        if (rw && ok) begin
            @(negedge clk);
            if (!cpu_valid) ok = 1'b0;
            rd = cpu_do;
        end
    endtask

    task automatic wait_done(input int d0, input int bound, output bit ok);
        int n;
        n = 0;
        while (done_cnt <= d0 && n < bound) begin @(negedge clk); #1; n++; end
        ok = (done_cnt > d0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int q0, d0, n;
        bit ok;
        logic [38:0] outs;
        repeat (3) @(negedge clk);
        outs = {cpu_gnt, cpu_do, cpu_valid, dma_busy, dma_data, dma_valid, dma_done,
                ram_cs, ram_rw, ram_addr, ram_di};
        n_cmp++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_state: got %h want 0", outs); end
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // reset in the middle of a burst
        q0 = dma_q.size(); d0 = done_cnt; n = 0;
        dma_go(12'h100, 8'd8);
        while (dma_q.size() - q0 < 3 && n < 50) begin @(negedge clk); #1; n++; end
        reset = 1'b0;
        #1;
        outs = {cpu_gnt, cpu_do, cpu_valid, dma_busy, dma_data, dma_valid, dma_done,
                ram_cs, ram_rw, ram_addr, ram_di};
        n_cmp++;
        if (outs !== '0 || n >= 50) begin
            n_fail++; $display("FAIL reset_mid_burst: got %h (waited %0d) want 0", outs, n);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        n_cmp++;
        if (dma_q.size() - q0 != 3 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL reset_abandon: bytes %0d dones %0d want 3 and 0", dma_q.size() - q0, done_cnt - d0);
        end

        // fresh burst after reset
        q0 = dma_q.size(); d0 = done_cnt;
        dma_go(12'h100, 8'd8);
        wait_done(d0, 50, ok);
        n_cmp++;
        if (!ok || dma_q.size() - q0 != 8) begin
            n_fail++; $display("FAIL reset_restart_len: got %0d bytes want 8", dma_q.size() - q0);
        end
        for (int i = 0; i < 8 && i < dma_q.size() - q0; i++) begin
            n_cmp++;
            if (dma_q[q0 + i] !== shadow[12'h100 + i]) begin
                n_fail++; $display("FAIL reset_restart_data[%0d]: got %h want %h", i, dma_q[q0 + i], shadow[12'h100 + i]);
            end
        end
    endtask

    task automatic test_cpu();
        logic [7:0] rd;
        int gw;
        bit ok;
        cpu_access(1'b1, 12'h234, 8'h00, rd, gw, ok);
        n_cmp++;
        if (!ok || gw != 2) begin n_fail++; $display("FAIL cpu_read_timing: gnt at %0d ok %0d want 2 and 1", gw, ok); end
        n_cmp++;
        if (rd !== 8'h5A) begin n_fail++; $display("FAIL cpu_read_data: got %h want 5a", rd); end

        cpu_access(1'b0, 12'h010, 8'hC3, rd, gw, ok);
        shadow[12'h010] = 8'hC3;
        n_cmp++;
        if (!ok || gw != 2) begin n_fail++; $display("FAIL cpu_write_timing: gnt at %0d want 2", gw); end
        cpu_access(1'b1, 12'h010, 8'h00, rd, gw, ok);
        n_cmp++;
        if (!ok || rd !== 8'hC3) begin n_fail++; $display("FAIL cpu_readback: got %h want c3", rd); end
    endtask

    task automatic test_wrap();
        int q0, d0;
        bit ok;
        logic [11:0] a;
        q0 = dma_q.size(); d0 = done_cnt;
        dma_go(12'hFFE, 8'd4);
        wait_done(d0, 40, ok);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (!ok || dma_q.size() - q0 != 4) begin n_fail++; $display("FAIL wrap_len: got %0d want 4", dma_q.size() - q0); end
        n_cmp++;
        if (done_cnt - d0 != 1 || done_at - q0 != 4) begin
            n_fail++; $display("FAIL wrap_done: dones %0d at byte %0d want 1 at 4", done_cnt - d0, done_at - q0);
        end
        for (int i = 0; i < 4 && i < dma_q.size() - q0; i++) begin
            a = 12'hFFE + 12'(i);
            n_cmp++;
            if (dma_q[q0 + i] !== shadow[a]) begin
                n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, dma_q[q0 + i], shadow[a]);
            end
            if (i > 0) begin
                n_cmp++;
                if (dma_cyc[q0 + i] - dma_cyc[q0 + i - 1] != 1) begin
                    n_fail++; $display("FAIL wrap_spacing[%0d]: got %0d want 1", i, dma_cyc[q0 + i] - dma_cyc[q0 + i - 1]);
                end
            end
        end
    endtask

    task automatic test_len0();
        int q0, d0, n, bad;
        bit ok;
        logic [11:0] b, a;
        b = 12'($urandom);
        q0 = dma_q.size(); d0 = done_cnt; n = 0; bad = 0;
        dma_go(b, 8'd0);
        while (dma_q.size() - q0 < 10 && n < 50) begin @(negedge clk); #1; n++; end
        dma_go(b + 12'h123, 8'd3);
        wait_done(d0, 400, ok);
        repeat (20) @(negedge clk);
        #1;
        n_cmp++;
        if (!ok || dma_q.size() - q0 != 256 || done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL len0_count: got %0d bytes %0d dones want 256 and 1", dma_q.size() - q0, done_cnt - d0);
        end
        for (int i = 0; i < 256 && i < dma_q.size() - q0; i++) begin
            a = b + 12'(i);
            if (dma_q[q0 + i] !== shadow[a]) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL len0_data: got %0d wrong bytes want 0", bad); end
        n_cmp++;
        if (dma_busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy: got %b want 0", dma_busy); end
    endtask

    task automatic test_contention();
        int s0, d0, q0, gw, span;
        bit ok, dok;
        logic [7:0] rd;
        logic [11:0] ra, bb;
        string got, want;
        ra = 12'($urandom); bb = 12'($urandom);
        repeat (2) @(negedge clk);
        s0 = slot_log.len(); d0 = done_cnt; q0 = dma_q.size();
        fork
            dma_go(bb, 8'd4);
            cpu_access(1'b1, ra, 8'h00, rd, gw, ok);
        join
        wait_done(d0, 40, dok);
        repeat (4) @(negedge clk);
        #1;
`ifdef VRAM_ARB_CPU_PREEMPT_EN
        want = "DCDDD"; span = 4;
`else
        want = "DDDDC"; span = 5;
`endif
        got = (slot_log.len() > s0) ? slot_log.substr(s0, slot_log.len() - 1) : "";
        n_cmp++;
        if (got != want) begin n_fail++; $display("FAIL contention_order: got %s want %s", got, want); end
        n_cmp++;
        if (slot_cyc.size() < s0 + 5 || slot_cyc[s0 + 4] - slot_cyc[s0] != span) begin
            n_fail++; $display("FAIL contention_span: want %0d cycles first to fifth slot", span);
        end
        n_cmp++;
        if (!ok || !dok || rd !== shadow[ra] || dma_q.size() - q0 != 4) begin
            n_fail++; $display("FAIL contention_data: cpu %h want %h, %0d bytes want 4", rd, shadow[ra], dma_q.size() - q0);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            int op = $urandom_range(0, 2);
            logic [11:0] a = 12'($urandom);
            logic [11:0] ra = 12'($urandom);
            logic [7:0] d = 8'($urandom);
            logic [7:0] blen = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 48));
            int nb = (blen == 0) ? 256 : int'(blen);
            int dly = $urandom_range(0, 6);
            int q0, d0, g0, gw, bad;
            logic [7:0] rd;
            bit ok, dok;
            logic [11:0] ea;
            if (op == 0) begin
                cpu_access(1'b0, a, d, rd, gw, ok);
                shadow[a] = d;
                n_cmp++;
                if (!ok) begin n_fail++; $display("FAIL rnd_write[%0d]: no grant", it); end
            end else if (op == 1) begin
                cpu_access(1'b1, a, 8'h00, rd, gw, ok);
                n_cmp++;
                if (!ok || rd !== shadow[a]) begin n_fail++; $display("FAIL rnd_read[%0d]: got %h want %h", it, rd, shadow[a]); end
            end else begin
                q0 = dma_q.size(); d0 = done_cnt; g0 = gnt_busy_cnt; bad = 0;
                fork
                    dma_go(a, blen);
                    begin
                        repeat (dly) @(posedge clk);
                        cpu_access(1'b1, ra, 8'h00, rd, gw, ok);
                    end
                join
                wait_done(d0, 400, dok);
                repeat (3) @(negedge clk);
                #1;
                for (int i = 0; i < nb && i < dma_q.size() - q0; i++) begin
                    ea = a + 12'(i);
                    if (dma_q[q0 + i] !== shadow[ea]) bad++;
                end
                n_cmp++;
                if (!dok || dma_q.size() - q0 != nb || bad != 0 || done_cnt - d0 != 1) begin
                    n_fail++;
                    $display("FAIL rnd_burst[%0d]: got %0d bytes %0d wrong %0d dones want %0d 0 1", it, dma_q.size() - q0, bad, done_cnt - d0, nb);
                end
                n_cmp++;
                if (!ok || rd !== shadow[ra]) begin n_fail++; $display("FAIL rnd_burst_read[%0d]: got %h want %h", it, rd, shadow[ra]); end
`ifndef VRAM_ARB_CPU_PREEMPT_EN
                n_cmp++;
                if (gnt_busy_cnt != g0) begin n_fail++; $display("FAIL rnd_no_preempt[%0d]: got %0d grants during burst want 0", it, gnt_busy_cnt - g0); end
`endif
            end
        end
    endtask

    initial begin
        reset = 1'b0; cpu_req = 1'b0; cpu_rw = 1'b1; cpu_addr = '0; cpu_di = '0;
        dma_start = 1'b0; dma_base = '0; dma_len = '0;
        for (int i = 0; i < 4096; i++) shadow[i] = init_byte(i);
        test_reset();
        test_cpu();
        test_wrap();
        test_len0();
        test_contention();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
